// File: rtl/key_debounce.sv
// key_debounce: two-flop synchronizer plus a per-key stability counter on the raw active-low
// push-buttons. Produces a registered active-high level and one-cycle press/release strobes.
// Optional feature: define KEY_DEBOUNCE_CHORD_EN to hold commits in a pending register and
// release them to the output stage only when no key is mid-window, so near-simultaneous
// presses appear together.
module key_debounce #(
    parameter int unsigned N_KEYS          = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic              clock_50,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] sync1_q, sync2_q;
    logic [CntW-1:0]   cnt_q [N_KEYS];
    logic [CntW-1:0]   cnt_d [N_KEYS];
    // Committed debounced value: "stable" in the default build, "pending" with chord alignment.
    logic [N_KEYS-1:0] commit_q, commit_d;
    logic [N_KEYS-1:0] stable_out;
    logic [N_KEYS-1:0] key_q, key_press_q, key_release_q;

    // Two-flop synchronizer on the inverted (active-high) pins.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ~key_n;
            sync2_q <= sync1_q;
        end
    end

    // Per-key stability counter: any return to the committed value restarts the window.
    always_comb begin
        cnt_d    = cnt_q;
        commit_d = commit_q;
        for (int k = 0; k < int'(N_KEYS); k++) begin
            if (sync2_q[k] == commit_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CntMax) begin
                commit_d[k] = sync2_q[k];
                cnt_d[k]    = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    // Counter and commit state registers.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            for (int k = 0; k < int'(N_KEYS); k++) begin
                cnt_q[k] <= '0;
            end
            commit_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            commit_q <= commit_d;
        end
    end

`ifdef KEY_DEBOUNCE_CHORD_EN
    logic              all_idle;
    logic [N_KEYS-1:0] stable_out_q;

    // Idle when no key has a window open and every synchronized input matches its commit.
    always_comb begin
        all_idle = (sync2_q == commit_q);
        for (int k = 0; k < int'(N_KEYS); k++) begin
            if (cnt_q[k] != '0) begin
                all_idle = 1'b0;
            end
        end
    end

    // Release pending commits to the output stage all at once when idle.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            stable_out_q <= '0;
        end else if (all_idle) begin
            stable_out_q <= commit_q;
        end
    end

    assign stable_out = stable_out_q;
`else
    assign stable_out = commit_q;
`endif

    // Registered output level and edge strobes aligned with the first cycle of the new level.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            key_q         <= '0;
            key_press_q   <= '0;
            key_release_q <= '0;
        end else begin
            key_q         <= stable_out;
            key_press_q   <= stable_out & ~key_q;
            key_release_q <= ~stable_out & key_q;
        end
    end

    assign key         = key_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;

endmodule
